// File: rtl/sram1rw_req_ctrl_if.sv
// Request/response port and SRAM macro pins of the 1RW SRAM request controller.
// master = requester/SRAM side, slave = controller side.
interface sram1rw_req_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 128
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_csb;
   logic                  sram_web;
   logic                  sram_oeb;
   logic [DATA_WIDTH-1:0] sram_i;
   logic [DATA_WIDTH-1:0] sram_o;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_o,
      input  req_ready, rsp_valid, rsp_rdata,
      input  sram_a, sram_csb, sram_web, sram_oeb, sram_i
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_o,
      output req_ready, rsp_valid, rsp_rdata,
      output sram_a, sram_csb, sram_web, sram_oeb, sram_i
   );
endinterface

// File: rtl/sram1rw_req_ctrl.sv
// Initiator-side controller for a 1RW SRAM macro: one op per cycle on the pins,
// read data captured into an in-order response FIFO with back-pressure.
module sram1rw_req_ctrl #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned RSP_DEPTH  = 2
) (
   input  logic               axis_clk,
   input  logic               axis_rst_n,
   sram1rw_req_ctrl_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
   localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

   logic                  ready_en_q;
   logic                  inflight_q;
   logic                  oeb_q;
   logic                  rsp_valid_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

   logic             push_c;
   logic             pop_c;
   logic [CNT_W-1:0] occ_c;
   logic             rd_ok_c;
   logic             req_ready_c;
   logic             fire_c;
   logic             rd_fire_c;

   assign push_c = inflight_q;
   assign pop_c  = rsp_valid_q & bus.rsp_ready;

   // A head entry leaving this cycle frees its slot, which keeps back-to-back reads at 1/cycle.
   assign occ_c   = count_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
   assign rd_ok_c = occ_c < CNT_W'(RSP_DEPTH);

   assign req_ready_c = ready_en_q & (bus.req_we | rd_ok_c);
   assign fire_c      = bus.req_valid & req_ready_c;
   assign rd_fire_c   = fire_c & ~bus.req_we;

   assign bus.req_ready = req_ready_c;
   assign bus.sram_csb  = ~fire_c;
   assign bus.sram_web  = ~(fire_c & bus.req_we);
   assign bus.sram_a    = fire_c ? bus.req_addr  : '0;
   assign bus.sram_i    = fire_c ? bus.req_wdata : '0;
   assign bus.sram_oeb  = oeb_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = mem_q[rd_ptr_q];

   // FIFO pointer and occupancy update
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         ready_en_q  <= 1'b0;
         inflight_q  <= 1'b0;
         oeb_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         ready_en_q  <= 1'b1;
         inflight_q  <= rd_fire_c;
         oeb_q       <= ~rd_fire_c;
         rsp_valid_q <= (count_d != '0);
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Data storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge axis_clk) begin
      if (push_c) mem_q[wr_ptr_q] <= bus.sram_o;
   end

   a_req_we_known: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
      bus.req_valid |-> !$isunknown(bus.req_we));

   a_no_overflow: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
      push_c |-> (count_q < CNT_W'(RSP_DEPTH)) || pop_c);

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// Directed self-checking bench for sram1rw_req_ctrl with a behavioural 1RW SRAM model.
module tb_sram1rw_req_ctrl;
   localparam int unsigned AW = 6;
   localparam int unsigned DW = 128;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   wr_cnt = 0;

   logic [DW-1:0] got_q[$];
   int            got_cyc[$];

   logic [DW-1:0] mem [64];
   logic [DW-1:0] dout;

   sram1rw_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sram1rw_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(2)) dut (
      .axis_clk   (clk),
      .axis_rst_n (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM macro model: data_out only changes on a read.
   always @(posedge clk) begin
      if (!bus.sram_csb) begin
         if (!bus.sram_web) begin
            mem[bus.sram_a] <= bus.sram_i;
            wr_cnt <= wr_cnt + 1;
         end else begin
            dout <= mem[bus.sram_a];
         end
      end
   end

   // Bus-hold garbage pattern stands in for Z so early/late captures show up.
   assign bus.sram_o = bus.sram_oeb ? {4{32'hBAD0BAD0}} : dout;

   always @(negedge clk) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
         got_q.push_back(bus.rsp_rdata);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int a);
      logic [31:0] w;
      w = 32'(a) * 32'h01010101;
      return {4{w}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      #1;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check("issue_timeout", DW'(n), DW'(0));
      step();
      idle_req();
   endtask

   task automatic drain(input int n);
      bus.rsp_ready = 1'b1;
      repeat (n) step();
   endtask

   logic [DW-1:0] w10;
   logic [DW-1:0] w40;
   logic [DW-1:0] exp5[10];
   int            drops;
   int            i;
   int            guard;
   logic          fired;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      w10 = {4{32'h12345678}};
      w40 = {4{32'hDEADBEEF}};

      // 1. Reset held with a pending write request
      rst_n = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 6'd3;
      bus.req_wdata = '1;
      repeat (3) step();
      check("rst_csb",       DW'(bus.sram_csb),  DW'(1));
      check("rst_web",       DW'(bus.sram_web),  DW'(1));
      check("rst_oeb",       DW'(bus.sram_oeb),  DW'(1));
      check("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
      check("rst_req_ready", DW'(bus.req_ready), DW'(0));
      check("rst_no_write",  DW'(wr_cnt),        DW'(0));
      idle_req();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_ready", DW'(bus.req_ready), DW'(1));

      // 2. Write then read with cycle-exact pin/latency checks
      issue(1'b1, 6'h05, {16{8'hA5}});
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'h05;
      #1;
      check("T_csb",   DW'(bus.sram_csb),  DW'(0));
      check("T_web",   DW'(bus.sram_web),  DW'(1));
      check("T_a",     DW'(bus.sram_a),    DW'(5));
      check("T_oeb",   DW'(bus.sram_oeb),  DW'(1));
      step();
      idle_req();
      #1;
      check("T1_oeb",       DW'(bus.sram_oeb),  DW'(0));
      check("T1_rsp_valid", DW'(bus.rsp_valid), DW'(0));
      check("T1_csb",       DW'(bus.sram_csb),  DW'(1));
      check("T1_a",         DW'(bus.sram_a),    DW'(0));
      step();
      check("T2_rsp_valid", DW'(bus.rsp_valid), DW'(1));
      check("T2_rdata",     bus.rsp_rdata,      {16{8'hA5}});
      check("T2_oeb",       DW'(bus.sram_oeb),  DW'(1));
      drain(3);
      check("wr_rd_count",  DW'(got_q.size()),  DW'(1));
      check("rsp_drained",  DW'(bus.rsp_valid), DW'(0));
      got_q.delete();
      got_cyc.delete();

      // 3. Streaming: 64 writes then 64 back-to-back reads
      for (int a = 0; a < 64; a++) issue(1'b1, AW'(a), pat(a));
      bus.rsp_ready = 1'b1;
      drops = 0;
      for (int a = 0; a < 64; a++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b0;
         bus.req_addr  = AW'(a);
         #1;
         if (!bus.req_ready) drops++;
         step();
      end
      idle_req();
      drain(5);
      check("stream_ready_drops", DW'(drops),        DW'(0));
      check("stream_count",       DW'(got_q.size()), DW'(64));
      for (int k = 0; k < got_q.size() && k < 64; k++)
         check($sformatf("stream_data%0d", k), got_q[k], pat(k));
      if (got_cyc.size() == 64)
         check("stream_span", DW'(got_cyc[63] - got_cyc[0]), DW'(63));
      got_q.delete();
      got_cyc.delete();

      // 4. Back-pressure: only two reads fit, writes still flow
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'd1;
      #1;
      check("bp_rd1_ready", DW'(bus.req_ready), DW'(1));
      step();
      bus.req_addr = 6'd2;
      #1;
      check("bp_rd2_ready", DW'(bus.req_ready), DW'(1));
      step();
      bus.req_addr = 6'd3;
      #1;
      check("bp_rd3_stall", DW'(bus.req_ready), DW'(0));
      step();
      check("bp_stall_c3",  DW'(bus.req_ready), DW'(0));
      check("bp_head",      bus.rsp_rdata,      pat(1));
      bus.req_we    = 1'b1;
      bus.req_addr  = 6'd10;
      bus.req_wdata = w10;
      #1;
      check("bp_wr_ready",  DW'(bus.req_ready), DW'(1));
      check("bp_wr_csb",    DW'(bus.sram_csb),  DW'(0));
      check("bp_wr_web",    DW'(bus.sram_web),  DW'(0));
      step();
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'd3;
      bus.req_wdata = '0;
      #1;
      check("bp_rd3_still_stall", DW'(bus.req_ready), DW'(0));
      check("bp_head_stable",     bus.rsp_rdata,      pat(1));
      check("bp_valid_held",      DW'(bus.rsp_valid), DW'(1));
      step();
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_rd3_release", DW'(bus.req_ready), DW'(1));
      step();
      idle_req();
      issue(1'b0, 6'd4, '0);
      drain(5);
      check("bp_count", DW'(got_q.size()), DW'(4));
      for (int k = 0; k < got_q.size() && k < 4; k++)
         check($sformatf("bp_data%0d", k), got_q[k], pat(k + 1));
      got_q.delete();
      got_cyc.delete();

      // 5. Toggling rsp_ready across pointer wrap; addr 10 holds the back-pressure write
      for (int k = 0; k < 10; k++) exp5[k] = (k == 2) ? w10 : pat(k + 8);
      i = 0;
      guard = 0;
      bus.rsp_ready = 1'b0;
      while (i < 10 && guard < 200) begin
         bus.rsp_ready = ~bus.rsp_ready;
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b0;
         bus.req_addr  = AW'(i + 8);
         #1;
         fired = bus.req_ready;
         step();
         if (fired) i++;
         guard++;
      end
      if (guard >= 200) check("wrap_timeout", DW'(guard), DW'(0));
      idle_req();
      drain(6);
      check("wrap_count", DW'(got_q.size()), DW'(10));
      for (int k = 0; k < got_q.size() && k < 10; k++)
         check($sformatf("wrap_data%0d", k), got_q[k], exp5[k]);
      got_q.delete();
      got_cyc.delete();

      // 6. Reset during an inflight read with a queued response
      issue(1'b1, 6'd40, w40);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'd40;
      step();
      step();
      idle_req();
      #1;
      check("mid_valid_before", DW'(bus.rsp_valid), DW'(1));
      rst_n = 1'b0;
      #1;
      check("mid_valid_drop", DW'(bus.rsp_valid), DW'(0));
      check("mid_oeb",        DW'(bus.sram_oeb),  DW'(1));
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      drain(6);
      check("mid_no_rsp", DW'(got_q.size()), DW'(0));
      issue(1'b0, 6'd40, '0);
      issue(1'b0, 6'd12, '0);
      drain(5);
      check("mid_reread_count", DW'(got_q.size()), DW'(2));
      if (got_q.size() >= 2) begin
         check("mid_reread40", got_q[0], w40);
         check("mid_reread12", got_q[1], pat(12));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
